// File: rtl/hms_clock_ctrl_pkg.sv
// Shared types and constants for the 12-hour HH:MM:SS clock controller.
// Digit order everywhere is {hh_tens, hh_ones, mm_tens, mm_ones, ss_tens, ss_ones}.
package hms_clock_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN,
      ST_LOAD,
      ST_WAIT_REL
   } state_t;

   typedef logic [7:0] bcd_t;

   localparam int          NUM_DIGITS    = 6;
   localparam logic [3:0]  DIGIT_MAX     = 4'd9;
   localparam logic [3:0]  TENS_MAX      = 4'd5;
   localparam logic [3:0]  HOUR_TENS_MAX = 4'd1;
   localparam logic [3:0]  HOUR_ONES_MAX = 4'd2;

   // True when h:m:s is a legal 12-hour BCD time (hour 01-12, min/sec 00-59).
   function automatic logic time_valid(input bcd_t h, input bcd_t m, input bcd_t s);
      return (h[3:0] <= DIGIT_MAX) && (h[7:4] <= DIGIT_MAX) &&
             (m[3:0] <= DIGIT_MAX) && (m[7:4] <= DIGIT_MAX) &&
             (s[3:0] <= DIGIT_MAX) && (s[7:4] <= DIGIT_MAX) &&
             (m <= 8'h59) && (s <= 8'h59) &&
             (((h >= 8'h01) && (h <= 8'h09)) || ((h >= 8'h10) && (h <= 8'h12)));
   endfunction

endpackage

// File: rtl/hms_clock_ctrl_count4.sv
// Loadable 4-bit digit counter; load has priority over enable.
module count4
   import hms_clock_ctrl_pkg::*;
#(
   parameter logic [3:0] RESET_VAL = 4'd0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ena,
   input  logic       load,
   input  logic [3:0] d,
   output logic [3:0] q
);

   always_ff @(posedge clk) begin
      if (reset)     q <= RESET_VAL;
      else if (load) q <= d;
      else if (ena)  q <= q + 4'd1;
   end

endmodule

// File: rtl/hms_clock_ctrl.sv
// Sequencing controller for six count4 digits: carry chain, 12->1 hour wrap,
// AM/PM flag, and a validated request/acknowledge time-set port.
module hms_clock_ctrl
   import hms_clock_ctrl_pkg::*;
#(
   parameter bcd_t RESET_HH = 8'h12,
   parameter bcd_t RESET_MM = 8'h00,
   parameter bcd_t RESET_SS = 8'h00,
   parameter logic RESET_PM = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ena,
   input  logic       set_req,
   input  logic [7:0] set_hh,
   input  logic [7:0] set_mm,
   input  logic [7:0] set_ss,
   input  logic       set_pm,
   output logic       set_ack,
   output logic       set_err,
   output logic [7:0] hh,
   output logic [7:0] mm,
   output logic [7:0] ss,
   output logic       pm
);

   localparam logic [4*NUM_DIGITS-1:0] RESET_DIGITS = {RESET_HH, RESET_MM, RESET_SS};

   state_t state, state_nxt;

   logic                           tick;
   logic                           load_cyc;
   logic                           set_ok;
   logic                           at_h11;
   logic                           at_h12;
   logic [4:0]                     cy;
   logic [NUM_DIGITS-1:0]          d_en;
   logic [NUM_DIGITS-1:0]          d_ld;
   logic [NUM_DIGITS-1:0][3:0]     d_in;
   logic [NUM_DIGITS-1:0][3:0]     q;

   // FSM
   always_ff @(posedge clk) begin
      if (reset) state <= ST_RUN;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      tick      = 1'b0;
      load_cyc  = 1'b0;
      case (state)
         ST_RUN: begin
            if (set_req) state_nxt = ST_LOAD;
            else         tick      = ena;
         end
         ST_LOAD: begin
            load_cyc  = 1'b1;
            state_nxt = ST_WAIT_REL;
         end
         ST_WAIT_REL: begin
            if (!set_req) state_nxt = ST_RUN;
         end
         default: state_nxt = ST_RUN;
      endcase
   end

   assign set_ok = time_valid(set_hh, set_mm, set_ss);

   // Ripple carry: cy[i] means digit i is being advanced this cycle.
   assign cy[0]  = tick;
   assign cy[1]  = cy[0] && (q[0] == DIGIT_MAX);
   assign cy[2]  = cy[1] && (q[1] == TENS_MAX);
   assign cy[3]  = cy[2] && (q[2] == DIGIT_MAX);
   assign cy[4]  = cy[3] && (q[3] == TENS_MAX);
   assign at_h12 = (q[5] == HOUR_TENS_MAX) && (q[4] == HOUR_ONES_MAX);
   assign at_h11 = (q[5] == HOUR_TENS_MAX) && (q[4] == HOUR_ONES_MAX - 4'd1);

   always_comb begin
      d_en = '0;
      d_ld = '0;
      d_in = '0;
      if (load_cyc && set_ok) begin
         d_ld = '1;
         d_in = {set_hh, set_mm, set_ss};
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (cy[i]) begin
               if (q[i] == (i[0] ? TENS_MAX : DIGIT_MAX)) d_ld[i] = 1'b1;
               else                                      d_en[i] = 1'b1;
            end
         end
         // Hours run 01..12 then back to 01, never through 00.
         if (cy[4]) begin
            if (at_h12) begin
               d_ld[5] = 1'b1;
               d_ld[4] = 1'b1;
               d_in[4] = 4'd1;
            end else if (q[4] == DIGIT_MAX) begin
               d_ld[4] = 1'b1;
               d_en[5] = 1'b1;
            end else begin
               d_en[4] = 1'b1;
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
      count4 #(
         .RESET_VAL (RESET_DIGITS[g*4 +: 4])
      ) u_cnt (
         .clk   (clk),
         .reset (reset),
         .ena   (d_en[g]),
         .load  (d_ld[g]),
         .d     (d_in[g]),
         .q     (q[g])
      );
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pm      <= RESET_PM;
         set_ack <= 1'b0;
         set_err <= 1'b0;
      end else begin
         set_ack <= load_cyc;
         set_err <= load_cyc && !set_ok;
         if (load_cyc && set_ok)  pm <= set_pm;
         else if (cy[4] && at_h11) pm <= ~pm;
      end
   end

   assign hh = {q[5], q[4]};
   assign mm = {q[3], q[2]};
   assign ss = {q[1], q[0]};

endmodule

// File: tb/tb_hms_clock_ctrl.sv
// Bench for hms_clock_ctrl: directed vector table, then random traffic against
// a seconds-of-day reference model.
module tb_hms_clock_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       ena = 1'b0;
   logic       set_req = 1'b0;
   logic [7:0] set_hh = 8'h00;
   logic [7:0] set_mm = 8'h00;
   logic [7:0] set_ss = 8'h00;
   logic       set_pm = 1'b0;
   logic       set_ack, set_err, pm;
   logic [7:0] hh, mm, ss;

   hms_clock_ctrl dut (
      .clk     (clk),
      .reset   (reset),
      .ena     (ena),
      .set_req (set_req),
      .set_hh  (set_hh),
      .set_mm  (set_mm),
      .set_ss  (set_ss),
      .set_pm  (set_pm),
      .set_ack (set_ack),
      .set_err (set_err),
      .hh      (hh),
      .mm      (mm),
      .ss      (ss),
      .pm      (pm)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst, ena, req;
      logic [7:0] shh, smm, sss;
      logic       spm;
      logic [7:0] ehh, emm, ess;
      logic       epm, eack, eerr;
   } vec_t;

   vec_t vecs[$];
   int   total = 0;
   int   bad = 0;

   // Reference model: time as seconds into the 12-hour cycle (0 = 12:00:00).
   int   mt = 0;
   int   mphase = 0;
   bit   mpm = 0;
   bit   mack = 0;
   bit   merr = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %07h want %07h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] to_bcd(input int v);
      return 8'((v / 10) * 16 + (v % 10));
   endfunction

   function automatic int fld_val(input logic [7:0] v);
      return int'(v[7:4]) * 10 + int'(v[3:0]);
   endfunction

   function automatic bit fld_ok(input logic [7:0] v, input int lo, input int hi);
      return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && fld_val(v) >= lo && fld_val(v) <= hi;
   endfunction

   function automatic logic [31:0] model_vec();
      int h;
      h = mt / 3600;
      if (h == 0) h = 12;
      return {5'd0, to_bcd(h), to_bcd((mt / 60) % 60), to_bcd(mt % 60), mpm, mack, merr};
   endfunction

   function automatic logic [31:0] dut_vec();
      return {5'd0, hh, mm, ss, pm, set_ack, set_err};
   endfunction

   task automatic model_update();
      mack = 0;
      merr = 0;
      if (reset) begin
         mt = 0; mpm = 0; mphase = 0;
      end else begin
         case (mphase)
            0: if (set_req) mphase = 1;
               else if (ena) begin
                  mt = (mt + 1) % 43200;
                  if (mt == 0) mpm = !mpm;
               end
            1: begin
               mack = 1;
               if (fld_ok(set_hh, 1, 12) && fld_ok(set_mm, 0, 59) && fld_ok(set_ss, 0, 59)) begin
                  mt  = (fld_val(set_hh) % 12) * 3600 + fld_val(set_mm) * 60 + fld_val(set_ss);
                  mpm = set_pm;
               end else merr = 1;
               mphase = 2;
            end
            default: if (!set_req) mphase = 0;
         endcase
      end
   endtask

   task automatic step(input logic r, input logic e, input logic q, input logic [7:0] h,
                       input logic [7:0] m, input logic [7:0] s, input logic p);
      @(negedge clk);
      reset = r; ena = e; set_req = q; set_hh = h; set_mm = m; set_ss = s; set_pm = p;
      @(posedge clk);
      model_update();
      #1;
      check("model", dut_vec(), model_vec());
   endtask

   task automatic row(input logic r, input logic e, input logic q, input logic [7:0] sh,
                      input logic [7:0] sm, input logic [7:0] s, input logic sp,
                      input logic [7:0] eh, input logic [7:0] em, input logic [7:0] es,
                      input logic ep, input logic ea, input logic ee);
      vec_t v;
      v.rst = r; v.ena = e; v.req = q; v.shh = sh; v.smm = sm; v.sss = s; v.spm = sp;
      v.ehh = eh; v.emm = em; v.ess = es; v.epm = ep; v.eack = ea; v.eerr = ee;
      vecs.push_back(v);
   endtask

   initial begin
      //  rst ena req  set_hh set_mm set_ss pm | exp hh  mm    ss   pm ack err
      row(1, 0, 0, 8'h00, 8'h00, 8'h00, 0, 8'h12, 8'h00, 8'h00, 0, 0, 0);
      row(0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 8'h12, 8'h00, 8'h01, 0, 0, 0);
      row(0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 8'h12, 8'h00, 8'h02, 0, 0, 0);
      row(0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 8'h12, 8'h00, 8'h03, 0, 0, 0);
      row(0, 1, 1, 8'h11, 8'h59, 8'h58, 0, 8'h12, 8'h00, 8'h03, 0, 0, 0);
      row(0, 0, 1, 8'h11, 8'h59, 8'h58, 0, 8'h11, 8'h59, 8'h58, 0, 1, 0);
      row(0, 0, 0, 8'h11, 8'h59, 8'h58, 0, 8'h11, 8'h59, 8'h58, 0, 0, 0);
      row(0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 8'h11, 8'h59, 8'h59, 0, 0, 0);
      row(0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 8'h12, 8'h00, 8'h00, 1, 0, 0);
      row(0, 0, 1, 8'h12, 8'h59, 8'h59, 1, 8'h12, 8'h00, 8'h00, 1, 0, 0);
      row(0, 0, 1, 8'h12, 8'h59, 8'h59, 1, 8'h12, 8'h59, 8'h59, 1, 1, 0);
      row(0, 0, 0, 8'h12, 8'h59, 8'h59, 1, 8'h12, 8'h59, 8'h59, 1, 0, 0);
      row(0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 8'h01, 8'h00, 8'h00, 1, 0, 0);
      row(0, 0, 1, 8'h13, 8'h00, 8'h00, 0, 8'h01, 8'h00, 8'h00, 1, 0, 0);
      row(0, 0, 1, 8'h13, 8'h00, 8'h00, 0, 8'h01, 8'h00, 8'h00, 1, 1, 1);
      row(0, 0, 0, 8'h13, 8'h00, 8'h00, 0, 8'h01, 8'h00, 8'h00, 1, 0, 0);
      row(0, 0, 1, 8'h01, 8'h60, 8'h00, 0, 8'h01, 8'h00, 8'h00, 1, 0, 0);
      row(0, 0, 1, 8'h01, 8'h60, 8'h00, 0, 8'h01, 8'h00, 8'h00, 1, 1, 1);
      row(0, 0, 0, 8'h01, 8'h60, 8'h00, 0, 8'h01, 8'h00, 8'h00, 1, 0, 0);
      row(0, 0, 1, 8'h01, 8'h00, 8'h0A, 0, 8'h01, 8'h00, 8'h00, 1, 0, 0);
      row(0, 0, 1, 8'h01, 8'h00, 8'h0A, 0, 8'h01, 8'h00, 8'h00, 1, 1, 1);
      row(0, 0, 0, 8'h01, 8'h00, 8'h0A, 0, 8'h01, 8'h00, 8'h00, 1, 0, 0);
      // set and tick together, then ticks during a 4-cycle request hold
      row(0, 1, 1, 8'h03, 8'h04, 8'h05, 0, 8'h01, 8'h00, 8'h00, 1, 0, 0);
      row(0, 1, 1, 8'h03, 8'h04, 8'h05, 0, 8'h03, 8'h04, 8'h05, 0, 1, 0);
      row(0, 1, 1, 8'h03, 8'h04, 8'h05, 0, 8'h03, 8'h04, 8'h05, 0, 0, 0);
      row(0, 1, 1, 8'h03, 8'h04, 8'h05, 0, 8'h03, 8'h04, 8'h05, 0, 0, 0);
      row(0, 1, 0, 8'h03, 8'h04, 8'h05, 0, 8'h03, 8'h04, 8'h05, 0, 0, 0);
      row(0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 8'h03, 8'h04, 8'h06, 0, 0, 0);
      // reset lands on the LOAD cycle
      row(0, 0, 1, 8'h05, 8'h00, 8'h00, 1, 8'h03, 8'h04, 8'h06, 0, 0, 0);
      row(1, 0, 1, 8'h05, 8'h00, 8'h00, 1, 8'h12, 8'h00, 8'h00, 0, 0, 0);
      row(0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 8'h12, 8'h00, 8'h01, 0, 0, 0);
      row(0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 8'h12, 8'h00, 8'h02, 0, 0, 0);
      // 09 -> 10 hour carry, then hour 00 rejected
      row(0, 0, 1, 8'h09, 8'h59, 8'h59, 0, 8'h12, 8'h00, 8'h02, 0, 0, 0);
      row(0, 0, 1, 8'h09, 8'h59, 8'h59, 0, 8'h09, 8'h59, 8'h59, 0, 1, 0);
      row(0, 0, 0, 8'h09, 8'h59, 8'h59, 0, 8'h09, 8'h59, 8'h59, 0, 0, 0);
      row(0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 8'h10, 8'h00, 8'h00, 0, 0, 0);
      row(0, 0, 1, 8'h00, 8'h00, 8'h00, 1, 8'h10, 8'h00, 8'h00, 0, 0, 0);
      row(0, 0, 1, 8'h00, 8'h00, 8'h00, 1, 8'h10, 8'h00, 8'h00, 0, 1, 1);
      row(0, 0, 0, 8'h00, 8'h00, 8'h00, 1, 8'h10, 8'h00, 8'h00, 0, 0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].rst, vecs[i].ena, vecs[i].req, vecs[i].shh, vecs[i].smm, vecs[i].sss,
              vecs[i].spm);
         check($sformatf("row%0d", i), dut_vec(),
               {5'd0, vecs[i].ehh, vecs[i].emm, vecs[i].ess, vecs[i].epm, vecs[i].eack,
                vecs[i].eerr});
      end

      begin
         logic       rq, r, e, p;
         logic [7:0] h, m, s;
         rq = 0; p = 0; h = 8'h12; m = 8'h00; s = 8'h00;
         for (int n = 0; n < 4000; n++) begin
            r = ($urandom_range(0, 199) == 0);
            e = $urandom_range(0, 1) == 1;
            if (!rq) begin
               if ($urandom_range(0, 1) == 1) begin
                  h = to_bcd($urandom_range(1, 12));
                  m = ($urandom_range(0, 2) == 0) ? 8'h59 : to_bcd($urandom_range(0, 59));
                  s = ($urandom_range(0, 2) == 0) ? 8'h59 : to_bcd($urandom_range(0, 59));
               end else begin
                  h = 8'($urandom); m = 8'($urandom); s = 8'($urandom);
               end
               p  = $urandom_range(0, 1) == 1;
               rq = ($urandom_range(0, 15) == 0);
            end else begin
               rq = ($urandom_range(0, 3) != 0);
            end
            step(r, e, rq, h, m, s, p);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
